map_read_arbiter: RTL and testbench

//  Shares one read port of the 80x60 map block memory between N characters (pacman + ghosts) for valid-move lookups.

---
 rtl/map_read_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_map_read_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/map_read_arbiter.sv
// Round-robin arbiter sharing one map block-memory read port between characters.
// Three row reads per grant build {Left,Down,Up,Right}; WRAP_TUNNEL_EN opens column edges.
module map_read_arbiter #(
   parameter int N_REQ    = 5,
   parameter int MAP_COLS = 80,
   parameter int MAP_ROWS = 60,
   parameter int MEM_LAT  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [7*N_REQ-1:0]    req_x,
   input  logic [6*N_REQ-1:0]    req_y,
   output logic [N_REQ-1:0]      ack,
   output logic [3:0]            moves,
   output logic                  busy,
   output logic [5:0]            mem_addr,
   output logic                  mem_en,
   input  logic [MAP_COLS-1:0]   mem_dout
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ABOVE,
      S_RD_SAME,
      S_RD_BELOW,
      S_WAIT,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      T_NONE,
      T_ABOVE,
      T_SAME,
      T_BELOW
   } tag_t;

   state_t        state_q, state_d;
   logic [IW-1:0] rr_q, rr_d;
   logic [IW-1:0] win_q, win_d;
   logic [6:0]    x_q, x_d;
   logic [5:0]    y_q, y_d;
   logic          ok_q, ok_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          up_q, up_d;
   logic          down_q, down_d;
   logic          left_q, left_d;
   logic          right_q, right_d;
   tag_t          tag_q [MEM_LAT];
   tag_t          tag_d;

   logic          found;
   logic [IW-1:0] pick;
   logic [6:0]    px;
   logic [5:0]    py;
   logic [6:0]    xl;
   logic [6:0]    xr;
   logic          left_same;
   logic          right_same;

   // First requester at or after rr_q, wrapping modulo N_REQ.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_q) + k) % N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   always_comb begin
      int pi;
      pi = int'(pick);
      px = req_x[7*pi +: 7];
      py = req_y[6*pi +: 6];
   end

   // Neighbour columns clamped so no index leaves the word.
   assign xl = (x_q == 7'd0) ? 7'd0 : x_q - 7'd1;
   assign xr = (x_q >= 7'(MAP_COLS-1)) ? x_q : x_q + 7'd1;

`ifdef WRAP_TUNNEL_EN
   assign left_same  = (x_q == 7'd0) ? 1'b1 : mem_dout[xl];
   assign right_same = (x_q >= 7'(MAP_COLS-1)) ? 1'b1 : mem_dout[xr];
`else
   assign left_same  = (x_q == 7'd0) ? 1'b0 : mem_dout[xl];
   assign right_same = (x_q >= 7'(MAP_COLS-1)) ? 1'b0 : mem_dout[xr];
`endif

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      win_d    = win_q;
      x_d      = x_q;
      y_d      = y_q;
      ok_d     = ok_q;
      cnt_d    = cnt_q;
      up_d     = up_q;
      down_d   = down_q;
      left_d   = left_q;
      right_d  = right_q;
      tag_d    = T_NONE;
      mem_en   = 1'b0;
      mem_addr = 6'd0;
      ack      = '0;
      moves    = 4'b0000;
      busy     = (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_RD_ABOVE;
               win_d   = pick;
               rr_d    = (int'(pick) == N_REQ-1) ? '0 : pick + 1'b1;
               x_d     = px;
               y_d     = py;
               ok_d    = (int'(px) < MAP_COLS) && (int'(py) < MAP_ROWS);
               up_d    = 1'b0;
               down_d  = 1'b0;
               left_d  = 1'b0;
               right_d = 1'b0;
            end
         end
         S_RD_ABOVE: begin
            state_d = S_RD_SAME;
            if (ok_q && y_q != 6'd0) begin
               mem_en   = 1'b1;
               mem_addr = y_q - 6'd1;
               tag_d    = T_ABOVE;
            end
         end
         S_RD_SAME: begin
            state_d = S_RD_BELOW;
            if (ok_q) begin
               mem_en   = 1'b1;
               mem_addr = y_q;
               tag_d    = T_SAME;
            end
         end
         S_RD_BELOW: begin
            state_d = S_WAIT;
            cnt_d   = CW'(MEM_LAT-1);
            if (ok_q && y_q != 6'(MAP_ROWS-1)) begin
               mem_en   = 1'b1;
               mem_addr = y_q + 6'd1;
               tag_d    = T_BELOW;
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) state_d = S_DONE;
            else cnt_d = cnt_q - 1'b1;
         end
         S_DONE: begin
            state_d    = S_IDLE;
            ack[win_q] = 1'b1;
            moves      = {left_q, down_q, up_q, right_q};
         end
         default: state_d = S_IDLE;
      endcase

      // Row word returns MEM_LAT cycles after its read cycle.
      unique case (tag_q[MEM_LAT-1])
         T_ABOVE: up_d   = mem_dout[x_q];
         T_BELOW: down_d = mem_dout[x_q];
         T_SAME: begin
            left_d  = left_same;
            right_d = right_same;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         win_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         ok_q    <= 1'b0;
         cnt_q   <= '0;
         up_q    <= 1'b0;
         down_q  <= 1'b0;
         left_q  <= 1'b0;
         right_q <= 1'b0;
         for (int k = 0; k < MEM_LAT; k++) tag_q[k] <= T_NONE;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         win_q    <= win_d;
         x_q      <= x_d;
         y_q      <= y_d;
         ok_q     <= ok_d;
         cnt_q    <= cnt_d;
         up_q     <= up_d;
         down_q   <= down_d;
         left_q   <= left_d;
         right_q  <= right_d;
         tag_q[0] <= tag_d;
         for (int k = 1; k < MEM_LAT; k++) tag_q[k] <= tag_q[k-1];
      end
   end

endmodule

// File: tb/tb_map_read_arbiter.sv
// Scoreboard bench for map_read_arbiter with behavioural block-memory models.
// A second instance exercises MEM_LAT=3.
`timescale 1ns/1ps
module tb_map_read_arbiter;

   localparam int L  = 1;
   localparam int L3 = 3;
`ifdef WRAP_TUNNEL_EN
   localparam logic WRAP = 1'b1;
`else
   localparam logic WRAP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst3;
   logic [4:0]  req, req3;
   logic [34:0] req_x, x3;
   logic [29:0] req_y, y3;
   logic [4:0]  ack, ack3;
   logic [3:0]  moves, moves3;
   logic        busy, busy3;
   logic [5:0]  mem_addr, addr3;
   logic        mem_en, en3;
   logic [79:0] mem_dout, dout3;

   map_read_arbiter #(.MEM_LAT(L)) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
      .ack(ack), .moves(moves), .busy(busy), .mem_addr(mem_addr),
      .mem_en(mem_en), .mem_dout(mem_dout)
   );

   map_read_arbiter #(.MEM_LAT(L3)) u_dut3 (
      .clk(clk), .rst(rst3), .req(req3), .req_x(x3), .req_y(y3),
      .ack(ack3), .moves(moves3), .busy(busy3), .mem_addr(addr3),
      .mem_en(en3), .mem_dout(dout3)
   );

   logic [79:0] map [60];
   logic [79:0] pipe1 [L];
   logic [79:0] pipe3 [L3];

   // Unread cycles return all ones so an unforced edge bit shows up as 1.
   always @(posedge clk) begin
      pipe1[0] <= (mem_en && mem_addr < 6'd60) ? map[mem_addr] : '1;
      for (int k = 1; k < L; k++) pipe1[k] <= pipe1[k-1];
      pipe3[0] <= (en3 && addr3 < 6'd60) ? map[addr3] : '1;
      for (int k = 1; k < L3; k++) pipe3[k] <= pipe3[k-1];
   end
   assign mem_dout = pipe1[L-1];
   assign dout3    = pipe3[L3-1];

   typedef struct {
      logic [4:0] oh;
      logic [3:0] mv;
      int         cyc;
   } exp_t;
   exp_t q[$];

   int cyc = 0;
   int chk_cnt = 0;
   int pass_cnt = 0;
   int en_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mem_en) begin
         en_cnt++;
         check("addr_range", 32'(mem_addr < 6'd60), 32'd1);
      end
      if (ack !== 5'd0) begin
         if (q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_ack: got ack=%b moves=%b expected none",
                     ack, moves);
         end else begin
            e = q.pop_front();
            check("ack_onehot", 32'(ack), 32'(e.oh));
            check("moves", 32'(moves), 32'(e.mv));
            check("ack_cycle", cyc, e.cyc);
            check("busy_at_ack", 32'(busy), 32'd1);
         end
      end
   end

   task automatic set_req(int i, int x, int y);
      req_x[7*i +: 7] = 7'(x);
      req_y[6*i +: 6] = 6'(y);
      req[i] = 1'b1;
   endtask

   task automatic expect_ack(int i, logic [3:0] mv, int c);
      exp_t e;
      e.oh  = 5'(1 << i);
      e.mv  = mv;
      e.cyc = c;
      q.push_back(e);
   endtask

   task automatic wait_drop(int i);
      int n = 0;
      while (ack[i] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk_cnt++;
         $display("FAIL timeout_ack%0d: got no ack expected ack", i);
      end
      req[i] = 1'b0;
   endtask

   task automatic single(int i, int x, int y, logic [3:0] mv, int reads);
      int e0;
      int c;
      e0 = en_cnt;
      c  = cyc;
      set_req(i, x, y);
      expect_ack(i, mv, c + 4 + L);
      wait_drop(i);
      check("read_count", en_cnt - e0, reads);
      @(negedge clk);
   endtask

   initial begin
      int c;
      int n;
      for (int r = 0; r < 60; r++) map[r] = '0;
      map[4][10] = 1'b1;  map[5][10] = 1'b1;  map[6][10] = 1'b1;
      map[5][11] = 1'b1;
      map[31][20] = 1'b1; map[30][19] = 1'b1;
      map[1][5] = 1'b1;   map[0][6] = 1'b1;   map[0][4] = 1'b1;
      map[58][40] = 1'b1; map[59][41] = 1'b1;
      map[9][79] = 1'b1;  map[10][78] = 1'b1;
      map[13][0] = 1'b1;

      rst = 1'b1; rst3 = 1'b1;
      req = '0; req_x = '0; req_y = '0;
      req3 = '0; x3 = '0; y3 = '0;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_moves", 32'(moves), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0; rst3 = 1'b0;
      @(negedge clk);

      single(0, 10, 5, 4'b0111, 3);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      c = cyc;
      set_req(0, 10, 5);
      set_req(1, 20, 30);
      set_req(2, 5, 0);
      set_req(3, 40, 59);
      set_req(4, 90, 3);
      expect_ack(0, 4'b0111, c + 4 + L);
      expect_ack(1, 4'b1100, c + 4 + L + 1 * (5 + L));
      expect_ack(2, 4'b1101, c + 4 + L + 2 * (5 + L));
      expect_ack(3, 4'b0011, c + 4 + L + 3 * (5 + L));
      expect_ack(4, 4'b0000, c + 4 + L + 4 * (5 + L));
      for (int i = 0; i < 5; i++) wait_drop(i);
      @(negedge clk);

      single(3, 40, 59, 4'b0011, 2);
      c = cyc;
      set_req(0, 10, 5);
      set_req(4, 20, 30);
      expect_ack(4, 4'b1100, c + 4 + L);
      expect_ack(0, 4'b0111, c + 4 + L + (5 + L));
      wait_drop(4);
      wait_drop(0);
      @(negedge clk);

      single(1, 5, 0, 4'b1101, 2);
      single(1, 40, 59, 4'b0011, 2);
      single(1, 90, 3, 4'b0000, 0);
      single(1, 10, 60, 4'b0000, 0);

      single(2, 79, 10, {1'b1, 1'b0, 1'b1, WRAP}, 3);
      single(2, 0, 12, {WRAP, 1'b1, 1'b0, 1'b0}, 3);

      set_req(3, 20, 30);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      req = '0;
      @(negedge clk);
      check("abort_ack", 32'(ack), 32'd0);
      check("abort_moves", 32'(moves), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_mem_en", 32'(mem_en), 32'd0);
      check("abort_mem_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      c = cyc;
      set_req(2, 10, 5);
      set_req(4, 90, 3);
      expect_ack(2, 4'b0111, c + 4 + L);
      expect_ack(4, 4'b0000, c + 4 + L + (5 + L));
      wait_drop(2);
      wait_drop(4);
      @(negedge clk);

      x3[6:0] = 7'd10;
      y3[5:0] = 6'd5;
      req3[0] = 1'b1;
      c = cyc;
      n = 0;
      while (ack3 === 5'd0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("lat3_ack", 32'(ack3), 32'd1);
      check("lat3_cycle", cyc, c + 4 + L3);
      check("lat3_moves", 32'(moves3), 32'b0111);
      req3 = '0;

      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_empty", q.size(), 0);
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
